// File: rtl/layer_stream_buffer.sv
// Parallel-to-serial buffer between two fully connected layers: captures a whole
// layer result in one cycle and replays it one activation per cycle, with a one-deep pending slot.
module layer_stream_buffer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons-1:0]           x_valid,
    input  logic [numNeurons*dataWidth-1:0] x_in,
    output logic [dataWidth-1:0]            out_data,
    output logic                            out_valid,
    output logic                            busy,
    output logic                            overflow,
    output logic                            sync_err
);

    localparam int IW = $clog2(numNeurons);
    localparam logic [IW-1:0] LAST = IW'(numNeurons - 1);

    typedef enum logic {IDLE, STREAM} state_t;
    typedef logic [numNeurons-1:0][dataWidth-1:0] vec_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          pend_full, pend_nxt;
    logic          load_a_x, load_a_p, load_p, ovf_set;
    vec_t          buf_a, buf_p;

    logic cap;
    logic skew;

    assign cap  = x_valid[0];
    assign skew = (x_valid != '0) && (x_valid != '1);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pend_nxt  = pend_full;
        load_a_x  = 1'b0;
        load_a_p  = 1'b0;
        load_p    = 1'b0;
        ovf_set   = 1'b0;
        case (state)
            IDLE: begin
                if (cap) begin
                    load_a_x  = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (idx != LAST) begin
                    idx_nxt = idx + 1'b1;
                    if (cap) begin
                        if (!pend_full) begin
                            load_p   = 1'b1;
                            pend_nxt = 1'b1;
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end
                end else begin
                    // Last element: hand over to the pending vector or a fresh capture without a gap
                    idx_nxt = '0;
                    if (pend_full) begin
                        load_a_p = 1'b1;
                        if (cap) load_p = 1'b1;
                        else     pend_nxt = 1'b0;
                    end else if (cap) begin
                        load_a_x = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            pend_full <= 1'b0;
            overflow  <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            pend_full <= pend_nxt;
            overflow  <= overflow | ovf_set;
            sync_err  <= sync_err | skew;
        end
    end

    // Data buffers carry no reset; their contents are only observed while streaming
    always_ff @(posedge clk) begin
        if (load_a_x)      buf_a <= x_in;
        else if (load_a_p) buf_a <= buf_p;
        if (load_p)        buf_p <= x_in;
    end

    assign out_valid = (state == STREAM);
    assign out_data  = out_valid ? buf_a[idx] : '0;
    assign busy      = out_valid | pend_full;

endmodule

// File: tb/tb_layer_stream_buffer.sv
// Self-checking bench for layer_stream_buffer: queue-based reference model compared
// every cycle, plus literal expectations from directed scenarios.
module tb_layer_stream_buffer;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    x_valid = '0;
    logic [N*DW-1:0] x_in = '0;
    logic [DW-1:0]   out_data;
    logic            out_valid, busy, overflow, sync_err;

    int checks = 0;
    int errors = 0;

    layer_stream_buffer #(.numNeurons(N), .dataWidth(DW)) dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in),
        .out_data(out_data), .out_valid(out_valid), .busy(busy),
        .overflow(overflow), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of words still to be emitted, one popped per clock.
    logic [DW-1:0] mq[$];
    logic          m_ovf  = 1'b0;
    logic          m_sync = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_sync = 1'b0;
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (x_valid != '0 && x_valid != '1) m_sync = 1'b1;
            if (x_valid[0]) begin
                // Room exists unless the current vector still has more than its final word left plus a full pending slot
                if (mq.size() <= N) begin
                    for (int i = 0; i < N; i++) mq.push_back(x_in[i*DW +: DW]);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic          ev;
        logic [DW-1:0] ed;
        ev = (mq.size() > 0);
        ed = ev ? mq[0] : '0;
        chk("model_out_valid", 32'(out_valid), 32'(ev));
        chk("model_out_data",  32'(out_data),  32'(ed));
        chk("model_busy",      32'(busy),      32'(ev));
        chk("model_overflow",  32'(overflow),  32'(m_ovf));
        chk("model_sync_err",  32'(sync_err),  32'(m_sync));
    end

    // Observe outputs for the current cycle, then drive inputs for the coming edge.
    task automatic cyc(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                       input logic ev, input logic [DW-1:0] ed);
        @(negedge clk);
        #1;
        chk("lit_valid", 32'(out_valid), 32'(ev));
        if (ev) chk("lit_data", 32'(out_data), 32'(ed));
        x_valid = v;
        x_in    = d;
    endtask

    logic [N*DW-1:0] v1, v2, v3;
    logic [N*DW-1:0] z;

    initial begin
        v1 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        v2 = {16'h0014, 16'h0013, 16'h0012, 16'h0011};
        v3 = {16'h0024, 16'h0023, 16'h0022, 16'h0021};
        z  = '0;

        // Reset with random activity on the inputs
        repeat (5) begin
            @(negedge clk);
            #1;
            x_valid = N'($urandom);
            x_in    = {$urandom, $urandom};
        end
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_flags", {29'd0, busy, overflow, sync_err}, 32'd0);
        x_valid = '0;
        x_in    = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) cyc('0, z, 1'b0, '0);

        // Single capture
        cyc('1, v1, 1'b0, '0);
        cyc('0, z, 1'b1, 16'h0001);
        cyc('0, z, 1'b1, 16'h0002);
        cyc('0, z, 1'b1, 16'h0003);
        cyc('0, z, 1'b1, 16'h0004);
        cyc('0, z, 1'b0, '0);
        chk("single_busy_after", 32'(busy), 32'd0);

        // Pending: second vector captured two edges later
        cyc('1, v1, 1'b0, '0);
        cyc('0, z, 1'b1, 16'h0001);
        cyc('1, v2, 1'b1, 16'h0002);
        cyc('0, z, 1'b1, 16'h0003);
        chk("pend_busy", 32'(busy), 32'd1);
        cyc('0, z, 1'b1, 16'h0004);
        cyc('0, z, 1'b1, 16'h0011);
        cyc('0, z, 1'b1, 16'h0012);
        cyc('0, z, 1'b1, 16'h0013);
        cyc('0, z, 1'b1, 16'h0014);
        chk("pend_ovf", 32'(overflow), 32'd0);
        cyc('0, z, 1'b0, '0);

        // Capture landing on the last element with empty pending slot
        cyc('1, v1, 1'b0, '0);
        cyc('0, z, 1'b1, 16'h0001);
        cyc('0, z, 1'b1, 16'h0002);
        cyc('0, z, 1'b1, 16'h0003);
        cyc('1, v2, 1'b1, 16'h0004);
        cyc('0, z, 1'b1, 16'h0011);
        cyc('0, z, 1'b1, 16'h0012);
        cyc('0, z, 1'b1, 16'h0013);
        cyc('0, z, 1'b1, 16'h0014);
        chk("last_ovf", 32'(overflow), 32'd0);
        cyc('0, z, 1'b0, '0);

        // Overflow: three consecutive captures, third dropped
        cyc('1, v1, 1'b0, '0);
        cyc('1, v2, 1'b1, 16'h0001);
        cyc('1, v3, 1'b1, 16'h0002);
        cyc('0, z, 1'b1, 16'h0003);
        chk("ovf_set", 32'(overflow), 32'd1);
        cyc('0, z, 1'b1, 16'h0004);
        cyc('0, z, 1'b1, 16'h0011);
        cyc('0, z, 1'b1, 16'h0012);
        cyc('0, z, 1'b1, 16'h0013);
        cyc('0, z, 1'b1, 16'h0014);
        cyc('0, z, 1'b0, '0);
        cyc('0, z, 1'b0, '0);

        // Skewed valids still capture on bit 0; then reset mid-stream
        cyc(4'b0011, v1, 1'b0, '0);
        cyc('0, z, 1'b1, 16'h0001);
        chk("skew_sync", 32'(sync_err), 32'd1);
        cyc('0, z, 1'b1, 16'h0002);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_flags", {29'd0, busy, overflow, sync_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) cyc('0, z, 1'b0, '0);

        // Randomized traffic with occasional asynchronous reset pulses
        repeat (1500) begin
            int r;
            @(negedge clk);
            #1;
            r = $urandom_range(0, 99);
            if (r < 70)      x_valid = '0;
            else if (r < 95) x_valid = '1;
            else             x_valid = N'($urandom);
            x_in = {$urandom, $urandom};
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                #2;
                rst = 1'b1;
            end
        end
        x_valid = '0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
